ex_multicycle_sequencer: RTL

Parametrised issue/complete sequencer for the EX stage that serialises one operation at a time to N multi-cycle functional units (multdiv, PPU, future posit/custom units).
- Issues a one-cycle start pulse to the selected unit and waits for that unit's valid.
- Registers the unit's result and generates ex_ready and result_valid.
- Adds flush, per-operation timeout with error flag, and a saturating completion counter.

---
 rtl/ex_multicycle_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ex_multicycle_sequencer.sv
// EX-stage issue/complete sequencer: serialises one operation at a time to N
// multi-cycle functional units, with flush, per-operation timeout and a completion count.
module ex_multicycle_sequencer #(
   parameter int DATA_W  = 32,
   parameter int N_UNITS = 3,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid_i,
   input  logic [SEL_W-1:0]            req_unit_i,
   input  logic                        flush_i,
   output logic [N_UNITS-1:0]          unit_start_o,
   input  logic [N_UNITS-1:0]          unit_valid_i,
   input  logic [N_UNITS*DATA_W-1:0]   unit_result_i,
   output logic [DATA_W-1:0]           result_o,
   output logic                        result_valid_o,
   output logic                        err_o,
   output logic                        ex_ready_o,
   output logic                        busy_o,
   output logic [CNT_W-1:0]            done_cnt_o
);

   localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
   localparam logic [SEL_W:0]  N_LIMIT = (SEL_W+1)'(N_UNITS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [SEL_W-1:0]    sel;
   logic [TO_W-1:0]     wait_cnt;
   logic                sel_valid;
   logic [DATA_W-1:0]   sel_result;
   logic [N_UNITS-1:0]  start_vec;
   logic                req_legal;

   // Only the selected unit is visible; every other unit's valid is ignored.
   always_comb begin
      sel_valid  = 1'b0;
      sel_result = '0;
      start_vec  = '0;
      for (int unsigned k = 0; k < N_UNITS; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_valid  = unit_valid_i[k];
            sel_result = unit_result_i[k*DATA_W +: DATA_W];
         end
         if (req_unit_i == SEL_W'(k)) start_vec[k] = 1'b1;
      end
   end

   assign req_legal = {1'b0, req_unit_i} < N_LIMIT;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         sel          <= '0;
         wait_cnt     <= '0;
         unit_start_o <= '0;
         result_o     <= '0;
         err_o        <= 1'b0;
         done_cnt_o   <= '0;
      end else begin
         unit_start_o <= '0;
         if (flush_i) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (req_valid_i) begin
                     if (req_legal) begin
                        sel          <= req_unit_i;
                        unit_start_o <= start_vec;
                        wait_cnt     <= '0;
                        state        <= S_WAIT;
                     end else begin
                        result_o <= '0;
                        err_o    <= 1'b1;
                        state    <= S_DONE;
                     end
                  end
               end
               S_WAIT: begin
                  if (sel_valid) begin
                     result_o <= sel_result;
                     err_o    <= 1'b0;
                     state    <= S_DONE;
                     if (done_cnt_o != '1) done_cnt_o <= done_cnt_o + CNT_W'(1);
                  end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
                     result_o <= '0;
                     err_o    <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     wait_cnt <= wait_cnt + TO_W'(1);
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign result_valid_o = (state == S_DONE);
   assign busy_o         = (state != S_IDLE);

   always_comb begin
      case (state)
         S_IDLE:  ex_ready_o = !req_valid_i;
         S_WAIT:  ex_ready_o = 1'b0;
         S_DONE:  ex_ready_o = 1'b1;
         default: ex_ready_o = 1'b0;
      endcase
   end

endmodule
